// File: rtl/sram6116_seq.sv
// sram6116_seq: turns one valid/ready request into 6116 SRAM pin activity (A, CS_b, WE_b, OE_b, D)
//   clk, rst            : clock and synchronous active-high reset
//   req_valid/req_ready : request handshake; a request is accepted only from IDLE
//   req_we/addr/wdata   : request fields, latched on acceptance
//   rsp_valid/rsp_rdata : one-cycle completion pulse; read data is captured at the end of the strobe
//   busy                : high whenever an access is in progress
//   A, CS_b, WE_b, OE_b : SRAM pins, all taken directly from flops
//   D                   : SRAM data bus, driven only while a write is in progress
module sram6116_seq #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    output logic              CS_b,
    output logic              WE_b,
    output logic              OE_b,
    inout  wire  [DATA_W-1:0] D
);
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                   : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3;

    if (SETUP_CYC < 1 || STROBE_CYC < 2 || HOLD_CYC < 1) begin : g_param_check
        $error("sram6116_seq: SETUP_CYC>=1, STROBE_CYC>=2 and HOLD_CYC>=1 are required");
    end

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic              r_d_oe;
    logic [DATA_W-1:0] r_wdata;
    logic              w_last;

    assign w_last    = r_cnt == CW'(1);
    assign req_ready = (r_state == IDLE) && !rst;
    assign busy      = r_state != IDLE;
    assign D         = r_d_oe ? r_wdata : {DATA_W{1'bz}};

    // Each phase change updates only the pins that belong to that boundary:
    // A/WE_b/D move at IDLE<->SETUP and HOLD->IDLE, CS_b/OE_b move at SETUP->STROBE->HOLD,
    // so the address/data/write-strobe never change on a CS_b edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_d_oe    <= 1'b0;
            r_wdata   <= '0;
            A         <= '0;
            CS_b      <= 1'b1;
            WE_b      <= 1'b1;
            OE_b      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state <= SETUP;
                        r_cnt   <= CW'(SETUP_CYC);
                        r_we    <= req_we;
                        r_d_oe  <= req_we;
                        r_wdata <= req_wdata;
                        A       <= req_addr;
                        WE_b    <= ~req_we;
                    end
                end
                SETUP: begin
                    if (w_last) begin
                        r_state <= STROBE;
                        r_cnt   <= CW'(STROBE_CYC);
                        CS_b    <= 1'b0;
                        OE_b    <= r_we;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                STROBE: begin
                    if (w_last) begin
                        r_state   <= HOLD;
                        r_cnt     <= CW'(HOLD_CYC);
                        CS_b      <= 1'b1;
                        OE_b      <= 1'b1;
                        rsp_valid <= 1'b1;
                        if (!r_we) rsp_rdata <= D;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_d_oe  <= 1'b0;
                        WE_b    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram6116_seq.sv
// tb_sram6116_seq: scoreboard bench for sram6116_seq with a 6116 memory model on the pins
module tb_sram6116_seq;
    localparam int S = 1, T = 2, H = 1;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [10:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, busy, CS_b, WE_b, OE_b;
    logic [7:0]  rsp_rdata;
    logic [10:0] A;
    wire  [7:0]  D;

    logic        v2 = 1'b0, we2 = 1'b0;
    logic [10:0] addr2 = '0;
    logic [7:0]  wd2 = '0;
    logic        rdy2, rv2, busy2, cs2, web2, oe2;
    logic [7:0]  rd2;
    logic [10:0] A2;
    wire  [7:0]  D2;

    always #5 clk = ~clk;

    sram6116_seq u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .A(A), .CS_b(CS_b), .WE_b(WE_b), .OE_b(OE_b), .D(D)
    );

    sram6116_seq #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
        .req_addr(addr2), .req_wdata(wd2), .rsp_valid(rv2), .rsp_rdata(rd2),
        .busy(busy2), .A(A2), .CS_b(cs2), .WE_b(web2), .OE_b(oe2), .D(D2)
    );

    // 6116 pin model: captures on the falling edge of CS_b, drives D while selected for a read
    logic [7:0] sram [2048];
    assign D  = (!CS_b && !OE_b && WE_b) ? sram[A] : 8'hzz;
    always @(negedge CS_b) if (!WE_b) sram[A] = D;
    assign D2 = (!cs2 && !oe2) ? ((A2 == 11'd0) ? 8'hA3 : 8'h11) : 8'hzz;

    int vec = 0, err = 0, cyc = 0, acc = -100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: memory contents change when a write is accepted; reads return them
    typedef struct {logic we; logic [7:0] data; int acc;} exp_t;
    exp_t        q[$];
    logic [7:0]  ref_mem [2048];
    logic        cur_we = 1'b0, in_rst = 1'b0, started = 1'b0;
    logic [10:0] cur_addr = '0;
    logic [7:0]  cur_wd = '0;

    always @(posedge clk) begin
        cyc++;
        in_rst = rst;
        if (rst) begin
            started = 1'b1;
            q.delete();
            acc = cyc - 100;
            cur_we = 1'b0;
            cur_addr = '0;
        end else if (req_valid && req_ready) begin
            acc = cyc;
            cur_we = req_we;
            cur_addr = req_addr;
            cur_wd = req_wdata;
            q.push_back('{req_we, req_we ? 8'h00 : ref_mem[req_addr], cyc});
            if (req_we) ref_mem[req_addr] = req_wdata;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (started && rsp_valid) begin
            if (q.size() == 0) begin
                vec++;
                err++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_cycle", cyc - e.acc + 1, S + T + 1);
                if (!e.we) chk("rsp_rdata", rsp_rdata, e.data);
            end
        end
    end

    // Pin monitor: expected pin levels from the access cycle number, plus the ordering rule
    logic        p_cs = 1'b1, p_we = 1'b1, p_doe = 1'b0, p_rst = 1'b1;
    logic [10:0] p_a = '0;
    logic [7:0]  p_d = '0;
    always @(negedge clk) begin
        int  rel;
        logic st, act, doe;
        doe = u_dut.r_d_oe;
        if (started) begin
            if (in_rst) begin
                chk("rst_pins", {CS_b, WE_b, OE_b, doe, busy}, 5'b11100);
                chk("rst_A", A, 0);
                chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
                if (rst) chk("rst_ready", req_ready, 0);
            end else begin
                rel = cyc - acc + 1;
                st  = rel >= S + 1 && rel <= S + T;
                act = rel >= 1 && rel <= S + T + H;
                chk("CS_b", CS_b, !st);
                chk("WE_b", WE_b, !(cur_we && act));
                chk("OE_b", OE_b, !(!cur_we && st));
                chk("D_drive", doe, cur_we && act);
                chk("A", A, cur_addr);
                chk("busy_ready", {busy, req_ready}, {act, !act && !rst});
                if (cur_we && act) chk("D_data", D, cur_wd);
                if (!p_rst && (CS_b != p_cs || !CS_b))
                    chk("pin_order", {A, WE_b, doe, doe ? D : 8'h00}, {p_a, p_we, p_doe, p_doe ? p_d : 8'h00});
            end
            p_cs = CS_b; p_we = WE_b; p_doe = doe; p_a = A; p_d = D; p_rst = in_rst;
        end
    end

    task automatic req(input logic we, input logic [10:0] addr, input logic [7:0] wd);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            vec++;
            err++;
            $display("FAIL req_timeout: got no req_ready expected acceptance (addr %0h)", addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1);
    end

    initial begin
        int a0, n;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h123; req_wdata = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        req(1'b1, 11'h2A5, 8'h5C);
        req(1'b0, 11'h2A5, 8'h00);
        req(1'b1, 11'h7FF, 8'h3C);
        for (int i = 0; i < 16; i++) req(1'b1, 11'(i), 8'($urandom));
        req(1'b0, 11'h7FF, 8'h00);
        a0 = acc;
        req(1'b0, 11'h001, 8'h00);
        chk("busy_accept_gap", acc - a0, S + T + H + 1);
        repeat (40) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk); #1;
            end
            req(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), 8'($urandom));
        end
        req(1'b0, 11'h2A5, 8'h00);
        @(posedge clk); #1;
        chk("mid_strobe_cs", CS_b, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req(1'b0, 11'h2A5, 8'h00);
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        v2 = 1'b1; we2 = 1'b0; addr2 = 11'h000;
        n = 0;
        while (!rdy2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("p2_ready", rdy2, 1);
        @(posedge clk); #1;
        v2 = 1'b0;
        for (int r = 1; r <= 11; r++) begin
            @(negedge clk);
            chk("p2_CS_b", cs2, !(r >= 4 && r <= 7));
            chk("p2_rsp_valid", rv2, r == 8);
            chk("p2_req_ready", rdy2, r >= 10);
            if (r == 8) chk("p2_rdata", rd2, 8'hA3);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/sram6116_seq.md
# sram6116_seq

Bus sequencer that sits directly upstream of the 6116 SRAM pin-level model. It turns a single-beat valid/ready request from a CPU-side master into 6116 pin activity on A, CS_b, WE_b, OE_b and the bidirectional D bus. Because the memory behind the 6116 model captures on the falling edge of CS_b, the sequencer sets up address, write strobe and write data before CS_b falls and holds them until after CS_b rises. Read data is returned on a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 11, address width (6116 = 2K x 8)
- DATA_W, 8, data width
- SETUP_CYC, 1, cycles A/WE_b/D are stable before CS_b falls; must be ≥1
- STROBE_CYC, 2, cycles CS_b is held low; must be ≥2; elaboration fails otherwise
- HOLD_CYC, 1, cycles A/WE_b/D are held after CS_b rises; must be ≥1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all flops rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  master request strobe
- req_ready  out  1  sequencer can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  access address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  DATA_W  read data; valid when rsp_valid is high after a read
- busy  out  1  high whenever state ≠ IDLE
- A  out  ADDR_W  SRAM address pins
- CS_b  out  1  chip select, active low
- WE_b  out  1  write enable, active low
- OE_b  out  1  output enable, active low
- D  inout  DATA_W  SRAM data bus; driven only during writes, otherwise high-Z

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter, width $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1), reloaded on every state entry.
- IDLE: req_ready = 1. On req_valid & req_ready, latch we/addr/wdata, load SETUP_CYC and go to SETUP. A request is accepted only from IDLE. req_valid is ignored while busy. No queueing.
- SETUP: A = latched addr, WE_b = ~we, OE_b = 1, CS_b = 1. D is driven with wdata if we, else high-Z. After SETUP_CYC cycles, go to STROBE.
- STROBE: CS_b = 0. For reads, OE_b = 0. A, WE_b and D are unchanged from SETUP. On the clock edge that ends the last STROBE cycle, a read captures D into rsp_rdata. After STROBE_CYC cycles, go to HOLD.
- HOLD: CS_b = 1, OE_b = 1. A, WE_b and D are held. rsp_valid = 1 in the first HOLD cycle only. After HOLD_CYC cycles, go to IDLE.
- IDLE pins: CS_b = 1, WE_b = 1, OE_b = 1, D high-Z, A holds its last value.
- Writes leave rsp_rdata unchanged.
- All pin outputs and rsp_* are driven straight from flops, with no combinational decode, so CS_b is glitch-free (it is a clock downstream).
- WE_b, A and D never change in the same cycle that CS_b changes.

## Timing
- Reset values: state = IDLE, A = 0, CS_b = 1, WE_b = 1, OE_b = 1, D high-Z, rsp_valid = 0, rsp_rdata = 0, busy = 0, req_ready = 0 while rst is high.
- Cycle numbering: the acceptance edge ends cycle 0.
  - Cycles 1..S: SETUP.
  - Cycles S+1..S+T: STROBE (CS_b low).
  - Cycles S+T+1..S+T+H: HOLD. rsp_valid is high in cycle S+T+1.
  - Cycle S+T+H+1: IDLE with req_ready = 1.
- Defaults: CS_b is low in cycles 2-3, rsp_valid is high in cycle 4, and the next request is accepted in cycle 5.
- Maximum throughput: one access per S+T+H+1 cycles.
- Reset mid-operation: on the next edge, go to IDLE with reset values. CS_b goes high, D is released, and no rsp_valid is issued. A write whose CS_b fall has already occurred may have been committed; this is accepted.
- req_valid asserted together with rst: ignored.

## Test plan
- Reset: hold rst 3 cycles with req_valid = 1 -> CS_b/WE_b/OE_b = 1, D = Z, A = 0, rsp_valid never pulses, req_ready = 0 during reset.
- Write then read, defaults: write addr 0x2A5 data 0x5C, then read 0x2A5 through the 6116 model -> rsp_rdata = 0x5C at rsp_valid in cycle 4. CS_b is low exactly cycles 2-3. WE_b is low cycles 1-4 for the write. D is Z throughout the read.
- Pin ordering check: with a monitor on every access, A/WE_b/D are stable from ≥1 cycle before CS_b falls to ≥1 cycle after CS_b rises. Any violation fails.
- Busy rejection: hold req_valid high with new addr 0x001 during an access to 0x7FF -> only 0x7FF is accessed until IDLE. 0x001 is then accepted in the first IDLE cycle.
- Parameters SETUP_CYC = 3, STROBE_CYC = 4, HOLD_CYC = 2: read of 0x000 holding 0xA3 -> CS_b low cycles 4-7, rsp_valid in cycle 8, rdata 0xA3, req_ready in cycle 10.
- Reset mid-STROBE on a read -> next cycle CS_b = 1, OE_b = 1, no rsp_valid, rsp_rdata = 0. A subsequent read completes normally.
